// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the RV32I 5-stage core.
// Drives the PC next-value select and stall, and the stall/flush controls of
// the IF/ID, ID/EX and EX/MEM registers. It also holds a redirect that
// resolves while the LSU is busy, keeps saturating stall/flush counters, and
// raises a sticky flag when the LSU stays busy for too long.
module hazard_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 1024,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_pc_curr,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_ex_rd_addr,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_redirect,
    input  logic [31:0]      i_ex_target,
    input  logic             i_lsu_busy,
    output logic [31:0]      o_pc_next,
    output logic             o_pc_stall,
    output logic             o_if_id_stall,
    output logic             o_if_id_flush,
    output logic             o_id_ex_stall,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_stall,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic             o_timeout
);

    localparam int unsigned         WCNT_W   = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0]   WAIT_MAX = WCNT_W'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic              pending_vld_q, pending_vld_d;
    logic [31:0]       pending_tgt_q, pending_tgt_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              timeout_q, timeout_d;

    logic              load_use;
    logic              redirect_applied;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    always_comb begin
        load_use = i_ex_mem_read && (i_ex_rd_addr != 5'd0) &&
                   ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
                    (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));
    end

    // Prioritised control: LSU freeze, held redirect, direct redirect, load-use.
    always_comb begin
        // NOTE: every output and next-state gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        o_pc_next        = i_pc_curr + 32'd4;
        o_pc_stall       = 1'b0;
        o_if_id_stall    = 1'b0;
        o_if_id_flush    = 1'b0;
        o_id_ex_stall    = 1'b0;
        o_id_ex_flush    = 1'b0;
        o_ex_mem_stall   = 1'b0;
        redirect_applied = 1'b0;
        pending_vld_d    = pending_vld_q;
        pending_tgt_d    = pending_tgt_q;

        if (i_lsu_busy) begin
            o_pc_stall     = 1'b1;
            o_if_id_stall  = 1'b1;
            o_id_ex_stall  = 1'b1;
            o_ex_mem_stall = 1'b1;
            // Only the oldest redirect seen during the wait is kept.
            if (i_ex_redirect && !pending_vld_q) begin
                pending_vld_d = 1'b1;
                pending_tgt_d = i_ex_target;
            end
        end else if (pending_vld_q) begin
            // Any redirect in EX now belongs to a younger instruction being flushed.
            o_pc_next        = pending_tgt_q;
            o_if_id_flush    = 1'b1;
            o_id_ex_flush    = 1'b1;
            redirect_applied = 1'b1;
            pending_vld_d    = 1'b0;
        end else if (i_ex_redirect) begin
            o_pc_next        = i_ex_target;
            o_if_id_flush    = 1'b1;
            o_id_ex_flush    = 1'b1;
            redirect_applied = 1'b1;
        end else if (load_use) begin
            o_pc_stall    = 1'b1;
            o_if_id_stall = 1'b1;
            o_id_ex_flush = 1'b1;
        end
    end

    // Wait tracking FSM plus the LSU wait counter and sticky timeout.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                // The cycle the LSU first reports busy is the first wait cycle.
                if (i_lsu_busy) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (!i_lsu_busy) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        timeout_d = timeout_q || (wait_cnt_d == WAIT_MAX);
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (o_pc_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect_applied && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops any held redirect and returns to RUN.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= RUN;
            pending_vld_q <= 1'b0;
            pending_tgt_q <= '0;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            timeout_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q       <= state_d;
            pending_vld_q <= pending_vld_d;
            pending_tgt_q <= pending_tgt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            timeout_q     <= timeout_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a rule-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_hazard_ctrl;

    localparam int unsigned WT = 8;
    localparam int unsigned CW = 4;
    localparam int          CNT_SAT = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic [31:0]   pc_curr;
    logic [4:0]    rs1, rs2, rd;
    logic          rs1_used, rs2_used, mem_read, redirect, busy;
    logic [31:0]   target;
    logic [31:0]   pc_next;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          timeout;

    int tests = 0;
    int fails = 0;
    bit mon_en = 0;

    hazard_ctrl #(.WAIT_TIMEOUT(WT), .CNT_W(CW)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_pc_curr     (pc_curr),
        .i_id_rs1_addr (rs1),
        .i_id_rs2_addr (rs2),
        .i_id_rs1_used (rs1_used),
        .i_id_rs2_used (rs2_used),
        .i_ex_rd_addr  (rd),
        .i_ex_mem_read (mem_read),
        .i_ex_redirect (redirect),
        .i_ex_target   (target),
        .i_lsu_busy    (busy),
        .o_pc_next     (pc_next),
        .o_pc_stall    (pc_stall),
        .o_if_id_stall (if_id_stall),
        .o_if_id_flush (if_id_flush),
        .o_id_ex_stall (id_ex_stall),
        .o_id_ex_flush (id_ex_flush),
        .o_ex_mem_stall(ex_mem_stall),
        .o_stall_cnt   (stall_cnt),
        .o_flush_cnt   (flush_cnt),
        .o_timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc_next;
        logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
        logic        applied;
    } ctl_t;

    logic [31:0] m_pend[$];  // redirect held across an LSU wait (at most one)
    int          m_streak;   // consecutive busy cycles, capped at WT
    bit          m_timeout;
    int          m_stalls;
    int          m_flushes;

    function automatic ctl_t model_ctl();
        ctl_t c;
        bit   lu;
        c = '0;
        c.pc_next = pc_curr + 32'd4;
        lu = mem_read && (rd != 0) &&
             ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
        if (busy) begin
            c.pc_stall = 1; c.if_id_stall = 1; c.id_ex_stall = 1; c.ex_mem_stall = 1;
        end else if (m_pend.size() != 0) begin
            c.pc_next = m_pend[0]; c.if_id_flush = 1; c.id_ex_flush = 1; c.applied = 1;
        end else if (redirect) begin
            c.pc_next = target; c.if_id_flush = 1; c.id_ex_flush = 1; c.applied = 1;
        end else if (lu) begin
            c.pc_stall = 1; c.if_id_stall = 1; c.id_ex_flush = 1;
        end
        return c;
    endfunction

    always @(posedge clk or posedge rst) begin
        ctl_t c;
        if (rst) begin
            m_pend.delete();
            m_streak  = 0;
            m_timeout = 0;
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            c = model_ctl();
            if (c.pc_stall) m_stalls = (m_stalls < CNT_SAT) ? m_stalls + 1 : CNT_SAT;
            if (c.applied)  m_flushes = (m_flushes < CNT_SAT) ? m_flushes + 1 : CNT_SAT;
            if (busy) begin
                m_streak = (m_streak < WT) ? m_streak + 1 : WT;
                if (m_streak == WT) m_timeout = 1;
                if (redirect && m_pend.size() == 0) m_pend.push_back(target);
            end else begin
                m_streak = 0;
                if (m_pend.size() != 0) void'(m_pend.pop_front());
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        ctl_t c;
        if (mon_en) begin
            c = model_ctl();
            check("m_pc_next",      pc_next,      c.pc_next);
            check("m_pc_stall",     pc_stall,     c.pc_stall);
            check("m_if_id_stall",  if_id_stall,  c.if_id_stall);
            check("m_if_id_flush",  if_id_flush,  c.if_id_flush);
            check("m_id_ex_stall",  id_ex_stall,  c.id_ex_stall);
            check("m_id_ex_flush",  id_ex_flush,  c.id_ex_flush);
            check("m_ex_mem_stall", ex_mem_stall, c.ex_mem_stall);
            check("m_stall_cnt",    stall_cnt,    m_stalls);
            check("m_flush_cnt",    flush_cnt,    m_flushes);
            check("m_timeout",      timeout,      m_timeout);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        rs1 = 0; rs2 = 0; rd = 0; rs1_used = 0; rs2_used = 0;
        mem_read = 0; redirect = 0; target = 0; busy = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        pc_curr = 32'h100;
        idle();
        #1 rst = 1;
        mon_en = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state / default flow
        pc_curr = 32'h100;
        @(negedge clk);
        check("rst_pc_next",   pc_next, 32'h104);
        check("rst_pc_stall",  pc_stall, 0);
        check("rst_if_flush",  if_id_flush, 0);
        check("rst_ex_flush",  id_ex_flush, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_timeout",   timeout, 0);

        // Load-use on rs2
        next(); mem_read = 1; rd = 5; rs2 = 5; rs2_used = 1;
        @(negedge clk);
        check("lu_pc_stall",    pc_stall, 1);
        check("lu_if_id_stall", if_id_stall, 1);
        check("lu_id_ex_flush", id_ex_flush, 1);
        check("lu_id_ex_stall", id_ex_stall, 0);
        next(); idle();
        @(negedge clk);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_released",  pc_stall, 0);
        // rd = x0 never hazards
        next(); mem_read = 1; rd = 0; rs2 = 0; rs2_used = 1;
        @(negedge clk);
        check("lu_x0_pc_stall", pc_stall, 0);
        // Matching rs1 that the instruction does not read
        next(); mem_read = 1; rd = 7; rs1 = 7; rs1_used = 0; rs2_used = 0;
        @(negedge clk);
        check("lu_unused_pc_stall", pc_stall, 0);
        next(); idle();
        @(negedge clk);
        check("lu_stall_cnt_hold", stall_cnt, 1);

        // Redirect wins over a simultaneous load-use
        next(); redirect = 1; target = 32'h2000; mem_read = 1; rd = 5; rs2 = 5; rs2_used = 1;
        @(negedge clk);
        check("rd_pc_next",  pc_next, 32'h2000);
        check("rd_if_flush", if_id_flush, 1);
        check("rd_ex_flush", id_ex_flush, 1);
        check("rd_pc_stall", pc_stall, 0);
        next(); idle();
        @(negedge clk);
        check("rd_flush_cnt", flush_cnt, 1);
        check("rd_after_pc",  pc_next, 32'h104);

        // Redirects during a 3-cycle LSU wait: the first one is held
        pc_curr = 32'h300;
        for (int k = 1; k <= 3; k++) begin
            next(); idle(); busy = 1;
            if (k == 2) begin redirect = 1; target = 32'h3000; end
            if (k == 3) begin redirect = 1; target = 32'h4000; end
            @(negedge clk);
            check("w_pc_stall",  pc_stall, 1);
            check("w_mem_stall", ex_mem_stall, 1);
            check("w_if_flush",  if_id_flush, 0);
            check("w_ex_flush",  id_ex_flush, 0);
        end
        next(); idle(); redirect = 1; target = 32'h5000;
        @(negedge clk);
        check("w_pend_pc",    pc_next, 32'h3000);
        check("w_pend_if",    if_id_flush, 1);
        check("w_pend_ex",    id_ex_flush, 1);
        check("w_stall_cnt",  stall_cnt, 4);
        next(); idle();
        @(negedge clk);
        check("w_after_pc",    pc_next, 32'h304);
        check("w_after_flush", if_id_flush, 0);
        check("w_flush_cnt",   flush_cnt, 2);

        // Timeout after the 8th consecutive busy cycle
        for (int k = 1; k <= 10; k++) begin
            next(); idle(); busy = 1;
            @(negedge clk);
            if (k == 8) check("to_not_yet", timeout, 0);
            if (k == 9) check("to_set", timeout, 1);
        end
        next(); idle();
        @(negedge clk);
        check("to_sticky",    timeout, 1);
        check("to_stall_cnt", stall_cnt, 14);
        // Stall counter saturation
        for (int k = 0; k < 3; k++) begin
            next(); idle(); busy = 1;
        end
        next(); idle();
        @(negedge clk);
        check("sat_stall_cnt", stall_cnt, 15);
        check("sat_timeout",   timeout, 1);

        // Async reset mid-wait with a held redirect
        next(); idle(); busy = 1; redirect = 1; target = 32'h6000;
        next(); idle(); busy = 1;
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("ar_stall_cnt", stall_cnt, 0);
        check("ar_flush_cnt", flush_cnt, 0);
        check("ar_timeout",   timeout, 0);
        @(posedge clk);
        #1 rst = 0;
        idle(); pc_curr = 32'h200;
        @(negedge clk);
        check("ar_pc_next",   pc_next, 32'h204);
        check("ar_if_flush",  if_id_flush, 0);
        check("ar_ex_flush",  id_ex_flush, 0);
        check("ar_pc_stall",  pc_stall, 0);
        next(); idle();
        @(negedge clk);
        check("ar_flush_cnt2", flush_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
